// File: rtl/synth_cmd_decoder_pkg.sv
// Shared command-decoder definitions: opcodes, payload lengths, FSM state encoding.
package synth_cmd_decoder_pkg;

  localparam logic [7:0] CMD_NOP             = 8'd0;
  localparam logic [7:0] CMD_SET_MOD_FCW     = 8'd1;
  localparam logic [7:0] CMD_SET_MOD_SHIFT   = 8'd2;
  localparam logic [7:0] CMD_NOTE_START      = 8'd3;
  localparam logic [7:0] CMD_NOTE_STOP       = 8'd4;
  localparam logic [7:0] CMD_SET_SYNTH_SHIFT = 8'd5;

  localparam logic [1:0] LEN_FCW   = 2'd3;
  localparam logic [1:0] LEN_SHIFT = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_EXEC    = 2'd2
  } state_t;

  // Zero means the opcode carries no payload (NOP or unknown).
  function automatic logic [1:0] payload_len(input logic [7:0] op);
    case (op)
      CMD_SET_MOD_FCW, CMD_NOTE_START, CMD_NOTE_STOP: payload_len = LEN_FCW;
      CMD_SET_MOD_SHIFT, CMD_SET_SYNTH_SHIFT:         payload_len = LEN_SHIFT;
      default:                                        payload_len = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/synth_cmd_decoder_if.sv
// Byte stream from the UART receiver into the command decoder.
// A byte transfers on a rising clock edge where rx_valid & rx_ready are both 1; the master holds
// rx_data stable while rx_valid is high, and rx_ready may drop regardless of rx_valid.
interface synth_cmd_decoder_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/synth_cmd_decoder_voice_alloc.sv
// Combinational voice lookup: which active voices hold a given FCW, and the lowest free voice.
module synth_cmd_decoder_voice_alloc #(
  parameter int N_VOICES = 4,
  parameter int FCW_W    = 24,
  parameter int IDX_W    = 2
) (
  input  logic [N_VOICES-1:0]       note_en,
  input  logic [N_VOICES*FCW_W-1:0] carrier_fcws,
  input  logic [FCW_W-1:0]          fcw,
  output logic [N_VOICES-1:0]       match_vec,
  output logic                      any_match,
  output logic [IDX_W-1:0]          free_idx,
  output logic                      any_free
);

  // Scanning downward lets the lowest free index win.
  always_comb begin
    match_vec = '0;
    free_idx  = '0;
    any_free  = 1'b0;
    for (int i = N_VOICES - 1; i >= 0; i--) begin
      match_vec[i] = note_en[i] && (carrier_fcws[i*FCW_W +: FCW_W] == fcw);
      if (!note_en[i]) begin
        free_idx = IDX_W'(i);
        any_free = 1'b1;
      end
    end
    any_match = |match_vec;
  end

endmodule

// File: rtl/synth_cmd_decoder.sv
// UART byte-stream command decoder driving the synth control registers and voice allocation.
module synth_cmd_decoder
  import synth_cmd_decoder_pkg::*;
#(
  parameter int          N_VOICES        = 4,
  parameter int          FCW_W           = 24,
  parameter int          SHIFT_W         = 5,
  parameter int          SYNTH_SHIFT_RST = 0,
  parameter int unsigned TIMEOUT_CYCLES  = 1_000_000
) (
  input  logic                      clk,
  input  logic                      rst,
  synth_cmd_decoder_if.slave        rx_if,
  output logic [FCW_W-1:0]          mod_fcw,
  output logic [SHIFT_W-1:0]        mod_shift,
  output logic [SHIFT_W-1:0]        synth_shift,
  output logic [N_VOICES*FCW_W-1:0] carrier_fcws,
  output logic [N_VOICES-1:0]       note_en,
  output logic                      cmd_err,
  output state_t                    dbg_state
);

  localparam int          IDX_W      = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
  localparam logic [31:0] TIMER_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

  state_t                    r_state, w_state_next;
  logic [7:0]                r_opcode;
  logic [FCW_W-1:0]          r_payload;
  logic [1:0]                r_remaining;
  logic [31:0]               r_timer;
  logic [FCW_W-1:0]          r_mod_fcw;
  logic [SHIFT_W-1:0]        r_mod_shift, r_synth_shift;
  logic [N_VOICES*FCW_W-1:0] r_carrier_fcws;
  logic [N_VOICES-1:0]       r_note_en;
  logic                      r_cmd_err;

  logic                      w_hs, w_timeout, w_err_next;
  logic [N_VOICES-1:0]       w_match_vec;
  logic                      w_any_match, w_any_free;
  logic [IDX_W-1:0]          w_free_idx;

  synth_cmd_decoder_voice_alloc #(
    .N_VOICES(N_VOICES), .FCW_W(FCW_W), .IDX_W(IDX_W)
  ) u_voice_alloc (
    .note_en(r_note_en), .carrier_fcws(r_carrier_fcws), .fcw(r_payload),
    .match_vec(w_match_vec), .any_match(w_any_match),
    .free_idx(w_free_idx), .any_free(w_any_free)
  );

  assign rx_if.rx_ready = (r_state != ST_EXEC);
  assign w_hs           = rx_if.rx_valid && rx_if.rx_ready;
  assign w_timeout      = (TIMEOUT_CYCLES != 0) && (r_timer == TIMER_LAST);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_err_next   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_hs) begin
          if (payload_len(rx_if.rx_data) != 2'd0) w_state_next = ST_PAYLOAD;
          else if (rx_if.rx_data != CMD_NOP)      w_err_next   = 1'b1;
        end
      end
      ST_PAYLOAD: begin
        if (w_hs) begin
          if (r_remaining == 2'd1) w_state_next = ST_EXEC;
        end else if (w_timeout) begin
          w_state_next = ST_IDLE;
          w_err_next   = 1'b1;
        end
      end
      ST_EXEC: begin
        w_state_next = ST_IDLE;
        if (r_opcode == CMD_NOTE_START && !w_any_match && !w_any_free) w_err_next = 1'b1;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_opcode       <= CMD_NOP;
      r_payload      <= '0;
      r_remaining    <= 2'd0;
      r_timer        <= 32'd0;
      r_mod_fcw      <= '0;
      r_mod_shift    <= '0;
      r_synth_shift  <= SHIFT_W'(SYNTH_SHIFT_RST);
      r_carrier_fcws <= '0;
      r_note_en      <= '0;
      r_cmd_err      <= 1'b0;
    end else begin
      r_cmd_err <= w_err_next;
      case (r_state)
        ST_IDLE: begin
          if (w_hs && payload_len(rx_if.rx_data) != 2'd0) begin
            r_opcode    <= rx_if.rx_data;
            r_remaining <= payload_len(rx_if.rx_data);
            r_payload   <= '0;
            r_timer     <= 32'd0;
          end
        end
        ST_PAYLOAD: begin
          // Little-endian: bytes enter at the top, so a 3-byte payload ends with byte 0 in [7:0]
          // and a 1-byte payload ends in the top byte.
          if (w_hs) begin
            r_payload   <= {rx_if.rx_data, r_payload[FCW_W-1:8]};
            r_remaining <= r_remaining - 2'd1;
            r_timer     <= 32'd0;
          end else begin
            r_timer     <= r_timer + 32'd1;
          end
        end
        ST_EXEC: begin
          case (r_opcode)
            CMD_SET_MOD_FCW:     r_mod_fcw     <= r_payload;
            CMD_SET_MOD_SHIFT:   r_mod_shift   <= r_payload[FCW_W-8 +: SHIFT_W];
            CMD_SET_SYNTH_SHIFT: r_synth_shift <= r_payload[FCW_W-8 +: SHIFT_W];
            CMD_NOTE_START: begin
              if (!w_any_match && w_any_free) begin
                for (int i = 0; i < N_VOICES; i++) begin
                  if (IDX_W'(i) == w_free_idx) begin
                    r_carrier_fcws[i*FCW_W +: FCW_W] <= r_payload;
                    r_note_en[i]                     <= 1'b1;
                  end
                end
              end
            end
            CMD_NOTE_STOP: r_note_en <= r_note_en & ~w_match_vec;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign mod_fcw      = r_mod_fcw;
  assign mod_shift    = r_mod_shift;
  assign synth_shift  = r_synth_shift;
  assign carrier_fcws = r_carrier_fcws;
  assign note_en      = r_note_en;
  assign cmd_err      = r_cmd_err;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_synth_cmd_decoder.sv
// Randomized self-checking bench for synth_cmd_decoder against a voice-table reference model.
module tb_synth_cmd_decoder;
  import synth_cmd_decoder_pkg::*;

  localparam int NV     = 4;
  localparam int FW     = 24;
  localparam int SW     = 5;
  localparam int TO     = 100;
  localparam int SNAP_W = FW + 2*SW + NV*FW + NV;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  synth_cmd_decoder_if ifc ();

  logic [FW-1:0]    mod_fcw;
  logic [SW-1:0]    mod_shift, synth_shift;
  logic [NV*FW-1:0] carrier_fcws;
  logic [NV-1:0]    note_en;
  logic             cmd_err;
  state_t           dbg_state;

  synth_cmd_decoder #(
    .N_VOICES(NV), .FCW_W(FW), .SHIFT_W(SW), .SYNTH_SHIFT_RST(0), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .rx_if(ifc),
    .mod_fcw(mod_fcw), .mod_shift(mod_shift), .synth_shift(synth_shift),
    .carrier_fcws(carrier_fcws), .note_en(note_en), .cmd_err(cmd_err), .dbg_state(dbg_state)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int err_count = 0;
  int exp_err = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // cmd_err pulses are counted once per cycle, so a stuck-high flag inflates the count.
  always @(negedge clk) if (cmd_err === 1'b1) err_count++;

  // ---------------- reference model ----------------
  logic [FW-1:0] m_mod_fcw;
  logic [SW-1:0] m_mod_shift, m_synth_shift;
  logic [FW-1:0] m_fcw [NV];
  bit            m_en  [NV];

  task automatic model_reset();
    m_mod_fcw = '0; m_mod_shift = '0; m_synth_shift = '0;
    for (int i = 0; i < NV; i++) begin m_fcw[i] = '0; m_en[i] = 1'b0; end
  endtask

  function automatic int cmd_len(input logic [7:0] op);
    if (op == 8'd1 || op == 8'd3 || op == 8'd4) return 3;
    if (op == 8'd2 || op == 8'd5) return 1;
    return 0;
  endfunction

  task automatic model_exec(input logic [7:0] op, input logic [FW-1:0] v);
    bit hit, placed;
    case (op)
      8'd0: ;
      8'd1: m_mod_fcw = v;
      8'd2: m_mod_shift = v[SW-1:0];
      8'd5: m_synth_shift = v[SW-1:0];
      8'd3: begin
        hit = 1'b0;
        for (int i = 0; i < NV; i++) if (m_en[i] && m_fcw[i] == v) hit = 1'b1;
        if (!hit) begin
          placed = 1'b0;
          for (int i = 0; i < NV; i++)
            if (!placed && !m_en[i]) begin m_fcw[i] = v; m_en[i] = 1'b1; placed = 1'b1; end
          if (!placed) exp_err++;
        end
      end
      8'd4: for (int i = 0; i < NV; i++) if (m_en[i] && m_fcw[i] == v) m_en[i] = 1'b0;
      default: exp_err++;
    endcase
  endtask

  // ---------------- scoreboard ----------------
  logic [SNAP_W-1:0] exp_q[$];

  function automatic logic [SNAP_W-1:0] model_snap();
    logic [NV*FW-1:0] cf;
    logic [NV-1:0]    ne;
    for (int i = 0; i < NV; i++) begin cf[i*FW +: FW] = m_fcw[i]; ne[i] = m_en[i]; end
    return {m_mod_fcw, m_mod_shift, m_synth_shift, cf, ne};
  endfunction

  task automatic sb_compare(input string tag);
    logic [SNAP_W-1:0] e, a;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_q_empty"}, 128'(exp_q.size()), 128'd1);
      return;
    end
    e = exp_q.pop_front();
    a = {mod_fcw, mod_shift, synth_shift, carrier_fcws, note_en};
    check_eq({tag, "_note_en"},     128'(a[NV-1:0]),               128'(e[NV-1:0]));
    check_eq({tag, "_carriers"},    128'(a[NV +: NV*FW]),          128'(e[NV +: NV*FW]));
    check_eq({tag, "_synth_shift"}, 128'(a[NV+NV*FW +: SW]),       128'(e[NV+NV*FW +: SW]));
    check_eq({tag, "_mod_shift"},   128'(a[NV+NV*FW+SW +: SW]),    128'(e[NV+NV*FW+SW +: SW]));
    check_eq({tag, "_mod_fcw"},     128'(a[NV+NV*FW+2*SW +: FW]),  128'(e[NV+NV*FW+2*SW +: FW]));
    check_eq({tag, "_err_count"},   128'(err_count),               128'(exp_err));
  endtask

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b);
    int gap, tries;
    gap = $urandom_range(0, 3);
    repeat (gap) @(negedge clk);
    ifc.rx_valid = 1'b1;
    ifc.rx_data  = b;
    tries = 0;
    while (!ifc.rx_ready && tries < 20) begin @(negedge clk); tries++; end
    if (!ifc.rx_ready) check_eq("rx_ready_wait", 128'(ifc.rx_ready), 128'd1);
    @(negedge clk);
    ifc.rx_valid = 1'b0;
  endtask

  task automatic send_cmd(input string tag, input logic [7:0] op, input logic [FW-1:0] v);
    send_byte(op);
    for (int i = 0; i < cmd_len(op); i++) send_byte(v[8*i +: 8]);
    model_exec(op, v);
    exp_q.push_back(model_snap());
    repeat (2) @(negedge clk);
    #1;
    sb_compare(tag);
  endtask

  // ---------------- stimulus ----------------
  logic [FW-1:0] pool [6];

  initial begin
    int r;
    logic [7:0] op;
    logic [FW-1:0] v;
    pool[0] = 24'h000001; pool[1] = 24'h2AAAAA; pool[2] = 24'h123456;
    pool[3] = 24'hFFFFFF; pool[4] = 24'h000100; pool[5] = 24'h800000;

    rst = 1'b1; ifc.rx_valid = 1'b0; ifc.rx_data = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    exp_q.push_back(model_snap());
    sb_compare("reset");
    check_eq("reset_rx_ready", 128'(ifc.rx_ready), 128'd1);
    check_eq("reset_state", 128'(dbg_state), 128'(ST_IDLE));
    check_eq("reset_cmd_err", 128'(cmd_err), 128'd0);

    // Register loads
    send_cmd("t1_mod_shift", 8'd2, 24'h000008);
    check_eq("t1_mod_shift_val", 128'(mod_shift), 128'd8);
    send_cmd("t2_mod_fcw", 8'd1, 24'h111111);
    check_eq("t2_mod_fcw_val", 128'(mod_fcw), 128'd1118481);
    send_cmd("t2_synth_shift", 8'd5, 24'h000002);

    // Note start / duplicate / stop
    send_cmd("t3_start", 8'd3, 24'h2AAAAA);
    check_eq("t3_en", 128'(note_en), 128'(4'b0001));
    send_cmd("t3_dup", 8'd3, 24'h2AAAAA);
    send_cmd("t3_stop", 8'd4, 24'h2AAAAA);
    check_eq("t3_carrier_kept", 128'(carrier_fcws[FW-1:0]), 128'd2796202);

    // Voice exhaustion and reuse of a freed slot
    for (int i = 1; i <= 5; i++) send_cmd("t4_fill", 8'd3, 24'h100000 + 24'(i));
    check_eq("t4_all_en", 128'(note_en), 128'hF);
    send_cmd("t4_stop_v1", 8'd4, 24'h100002);
    send_cmd("t4_reuse", 8'd3, 24'h100009);
    check_eq("t4_voice1", 128'(carrier_fcws[FW +: FW]), 128'h100009);

    // Bad opcode and payload timeout
    send_cmd("t5_bad_op", 8'h07, 24'h0);
    send_byte(8'd1);
    send_byte(8'h34);
    repeat (TO - 5) @(negedge clk);
    #1;
    check_eq("t5_no_early_timeout", 128'(err_count), 128'(exp_err));
    repeat (10) @(negedge clk);
    #1;
    exp_err++;
    check_eq("t5_timeout_err", 128'(err_count), 128'(exp_err));
    check_eq("t5_timeout_idle", 128'(dbg_state), 128'(ST_IDLE));
    send_cmd("t5_after_timeout", 8'd2, 24'h000003);

    // Reset mid-payload with rx_valid held high
    send_byte(8'd3);
    send_byte(8'hAA);
    ifc.rx_valid = 1'b1;
    ifc.rx_data  = 8'hAA;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    ifc.rx_valid = 1'b0;
    rst = 1'b0;
    model_reset();
    #1;
    exp_q.push_back(model_snap());
    sb_compare("t6_reset");
    check_eq("t6_rx_ready", 128'(ifc.rx_ready), 128'd1);
    check_eq("t6_state", 128'(dbg_state), 128'(ST_IDLE));
    send_cmd("t6_fresh", 8'd3, 24'h0ABCDE);

    // Random command mix over a small FCW pool so matches and exhaustion recur
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0:       op = 8'd0;
        1:       op = 8'd1;
        2:       op = 8'd2;
        3, 4:    op = 8'd3;
        5, 6:    op = 8'd4;
        7:       op = 8'd5;
        default: op = 8'($urandom_range(6, 255));
      endcase
      if (op == 8'd2 || op == 8'd5) v = 24'($urandom_range(0, 255));
      else                          v = pool[$urandom_range(0, 5)];
      send_cmd("rand", op, v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
